// File: rtl/match_game_ctrl_if.sv
// rtl/match_game_ctrl_if.sv - button inputs and board state outputs of the match game controller
interface match_game_ctrl_if;
    logic       btnA;
    logic       btnB;
    logic       btnC;
    logic       btnD;
    logic [1:0] actionA;
    logic [1:0] actionB;
    logic [1:0] actionC;
    logic [1:0] actionD;
    logic       winscreen;
    logic [7:0] moves;
    logic       busy;

    modport master (
        output btnA, btnB, btnC, btnD,
        input  actionA, actionB, actionC, actionD, winscreen, moves, busy
    );

    modport slave (
        input  btnA, btnB, btnC, btnD,
        output actionA, actionB, actionC, actionD, winscreen, moves, busy
    );
endinterface

// File: rtl/match_game_ctrl.sv
// rtl/match_game_ctrl.sv - four-square match game FSM; MATCH_GAME_DEBOUNCE_EN adds button debounce
module match_game_ctrl #(
    parameter int REVEAL_TICKS   = 25000000,
    parameter int WIN_TICKS      = 75000000,
    parameter int DEBOUNCE_TICKS = 250000
) (
    input  logic         clk25MHz,
    input  logic         rst,
    match_game_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ONE, REVEAL, WIN} state_t;

    localparam logic [1:0] HIDDEN   = 2'b00;
    localparam logic [1:0] SELECTED = 2'b01;
    localparam logic [1:0] SHOWN    = 2'b10;
    localparam logic [1:0] CLEARED  = 2'b11;

    logic [3:0] btn_raw;
    logic [3:0] sync1, sync2;
    logic [3:0] level, level_q, press_q;

    assign btn_raw = {bus.btnD, bus.btnC, bus.btnB, bus.btnA};

    always_ff @(posedge clk25MHz) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            level_q <= '0;
            press_q <= '0;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            level_q <= level;
            press_q <= level & ~level_q;
        end
    end

`ifdef MATCH_GAME_DEBOUNCE_EN
    localparam int DBW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

    logic [3:0]           filt;
    logic [3:0][DBW-1:0]  db_cnt;

    // Counter runs only while the synchronised level disagrees with the filtered one.
    always_ff @(posedge clk25MHz) begin
        if (rst) begin
            filt   <= '0;
            db_cnt <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DBW'(DEBOUNCE_TICKS - 1)) begin
                    filt[i]   <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign level = filt;
`else
    assign level = sync2;
`endif

    logic       sel_valid;
    logic [1:0] sel_idx;

    always_comb begin
        sel_valid = 1'b1;
        sel_idx   = 2'd0;
        if (press_q[0])      sel_idx = 2'd0;
        else if (press_q[1]) sel_idx = 2'd1;
        else if (press_q[2]) sel_idx = 2'd2;
        else if (press_q[3]) sel_idx = 2'd3;
        else                 sel_valid = 1'b0;
    end

    state_t          state, state_n;
    logic [3:0][1:0] code, code_n;
    logic [31:0]     timer, timer_n;
    logic [7:0]      moves, moves_n;
    logic [1:0]      first, first_n, second, second_n;
    logic            win, win_n;
    logic            busy, busy_n;

    always_ff @(posedge clk25MHz) begin
        if (rst) begin
            state  <= IDLE;
            code   <= '0;
            timer  <= '0;
            moves  <= '0;
            first  <= '0;
            second <= '0;
            win    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            code   <= code_n;
            timer  <= timer_n;
            moves  <= moves_n;
            first  <= first_n;
            second <= second_n;
            win    <= win_n;
            busy   <= busy_n;
        end
    end

    always_comb begin
        state_n  = state;
        code_n   = code;
        timer_n  = timer;
        moves_n  = moves;
        first_n  = first;
        second_n = second;
        win_n    = win;
        case (state)
            IDLE: begin
                if (sel_valid && code[sel_idx] == HIDDEN) begin
                    code_n[sel_idx] = SELECTED;
                    first_n         = sel_idx;
                    state_n         = ONE;
                end
            end
            ONE: begin
                if (sel_valid) begin
                    if (sel_idx == first) begin
                        code_n[first] = HIDDEN;
                        state_n       = IDLE;
                    end else if (code[sel_idx] == HIDDEN) begin
                        code_n[first]   = SHOWN;
                        code_n[sel_idx] = SHOWN;
                        second_n        = sel_idx;
                        moves_n         = (moves == 8'hFF) ? moves : moves + 8'd1;
                        timer_n         = 32'(REVEAL_TICKS - 1);
                        state_n         = REVEAL;
                    end
                end
            end
            REVEAL: begin
                if (timer == '0) begin
                    // Indices A=0..D=3: the pairs {A,D} and {B,C} are exactly those summing to 3.
                    if (2'(first + second) == 2'd3) begin
                        code_n[first]  = CLEARED;
                        code_n[second] = CLEARED;
                    end else begin
                        code_n[first]  = HIDDEN;
                        code_n[second] = HIDDEN;
                    end
                    if (code_n == {4{CLEARED}}) begin
                        timer_n = 32'(WIN_TICKS - 1);
                        win_n   = 1'b1;
                        state_n = WIN;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    timer_n = timer - 32'd1;
                end
            end
            WIN: begin
                if (timer == '0) begin
                    code_n  = '0;
                    win_n   = 1'b0;
                    moves_n = '0;
                    state_n = IDLE;
                end else begin
                    timer_n = timer - 32'd1;
                end
            end
            default: begin
                code_n  = '0;
                win_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n == REVEAL) || (state_n == WIN);
    end

    assign bus.actionA   = code[0];
    assign bus.actionB   = code[1];
    assign bus.actionC   = code[2];
    assign bus.actionD   = code[3];
    assign bus.winscreen = win;
    assign bus.moves     = moves;
    assign bus.busy      = busy;
endmodule
